// File: rtl/parking_event_driver_if.sv
// Signal bundle between the parking event driver and its environment: raw loop detectors,
// controller status in, and the sensor/switch stimulus presented to the parking controller.
interface parking_event_driver_if;
  logic       entry_raw;
  logic       exit_raw;
  logic [1:0] exit_slot;
  logic [3:0] parking_slots;
  logic       door_open;
  logic       entry_sensor;
  logic       exit_sensor;
  logic [1:0] switch;
  logic       busy;
  logic       rejected;

  modport master (
    output entry_raw, exit_raw, exit_slot, parking_slots, door_open,
    input  entry_sensor, exit_sensor, switch, busy, rejected
  );

  modport slave (
    input  entry_raw, exit_raw, exit_slot, parking_slots, door_open,
    output entry_sensor, exit_sensor, switch, busy, rejected
  );
endinterface

// File: rtl/parking_event_driver.sv
// Debounces entry/exit loop detectors, queues one pending event per direction and presents
// accepted events to the parking controller until door_open, with timeout and idle gap.
module parking_event_driver #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned GAP      = 2
) (
  input logic                  clk,
  input logic                  reset,
  parking_event_driver_if.slave bus
);
  localparam int unsigned DbW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned HoldW = $clog2(HOLD_MAX + 1);
  localparam int unsigned GapW  = $clog2(GAP + 1);
  localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE);
  localparam logic [HoldW-1:0] HoldEnd = HoldW'(HOLD_MAX - 1);
  localparam logic [GapW-1:0]  GapEnd  = GapW'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

  state_e           state_q, state_d;
  logic [DbW-1:0]   entry_cnt_q, entry_cnt_d, exit_cnt_q, exit_cnt_d;
  logic             entry_ev, exit_ev, entry_acc, exit_acc;
  logic             pend_entry_q, pend_entry_d, pend_exit_q, pend_exit_d;
  logic             clr_entry, clr_exit;
  logic [1:0]       slot_q, slot_d;
  logic             drive_exit_q, drive_exit_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             entry_sensor_q, entry_sensor_d, exit_sensor_q, exit_sensor_d;
  logic [1:0]       switch_q, switch_d;
  logic             rejected_q, rejected_d;

  // Debounce: count while high, saturate, clear on any low; fire only on reaching DEBOUNCE.
  always_comb begin
    entry_cnt_d = '0;
    exit_cnt_d  = '0;
    if (bus.entry_raw) entry_cnt_d = (entry_cnt_q == DbMax) ? entry_cnt_q : entry_cnt_q + 1'b1;
    if (bus.exit_raw)  exit_cnt_d  = (exit_cnt_q == DbMax) ? exit_cnt_q : exit_cnt_q + 1'b1;
  end

  assign entry_ev = bus.entry_raw && (entry_cnt_q == DbMax - 1'b1);
  assign exit_ev  = bus.exit_raw && (exit_cnt_q == DbMax - 1'b1);

  // A flag being retired this cycle frees its slot, so a coincident new event is kept.
  assign entry_acc    = entry_ev && (!pend_entry_q || clr_entry);
  assign exit_acc     = exit_ev && (!pend_exit_q || clr_exit);
  assign pend_entry_d = entry_acc || (pend_entry_q && !clr_entry);
  assign pend_exit_d  = exit_acc || (pend_exit_q && !clr_exit);
  assign slot_d       = exit_acc ? bus.exit_slot : slot_q;

  always_comb begin
    state_d        = state_q;
    drive_exit_d   = drive_exit_q;
    hold_d         = hold_q;
    gap_d          = gap_q;
    clr_entry      = 1'b0;
    clr_exit       = 1'b0;
    rejected_d     = 1'b0;
    entry_sensor_d = entry_sensor_q;
    exit_sensor_d  = exit_sensor_q;
    switch_d       = switch_q;
    unique case (state_q)
      StIdle: begin
        hold_d = '0;
        gap_d  = '0;
        if (pend_exit_q) begin
          if (!bus.parking_slots[slot_q]) begin
            rejected_d = 1'b1;
            clr_exit   = 1'b1;
          end else begin
            state_d       = StDrive;
            drive_exit_d  = 1'b1;
            exit_sensor_d = 1'b1;
            switch_d      = slot_q;
          end
        end else if (pend_entry_q) begin
          if (&bus.parking_slots) begin
            rejected_d = 1'b1;
            clr_entry  = 1'b1;
          end else begin
            state_d        = StDrive;
            drive_exit_d   = 1'b0;
            entry_sensor_d = 1'b1;
            switch_d       = 2'b00;
          end
        end
      end
      StDrive: begin
        hold_d = hold_q + 1'b1;
        if (bus.door_open || hold_q == HoldEnd) begin
          rejected_d     = !bus.door_open;
          clr_exit       = drive_exit_q;
          clr_entry      = !drive_exit_q;
          state_d        = StGap;
          gap_d          = '0;
          entry_sensor_d = 1'b0;
          exit_sensor_d  = 1'b0;
          switch_d       = 2'b00;
        end
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapEnd) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      entry_cnt_q    <= '0;
      exit_cnt_q     <= '0;
      pend_entry_q   <= 1'b0;
      pend_exit_q    <= 1'b0;
      slot_q         <= 2'b00;
      drive_exit_q   <= 1'b0;
      hold_q         <= '0;
      gap_q          <= '0;
      entry_sensor_q <= 1'b0;
      exit_sensor_q  <= 1'b0;
      switch_q       <= 2'b00;
      rejected_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_cnt_q    <= entry_cnt_d;
      exit_cnt_q     <= exit_cnt_d;
      pend_entry_q   <= pend_entry_d;
      pend_exit_q    <= pend_exit_d;
      slot_q         <= slot_d;
      drive_exit_q   <= drive_exit_d;
      hold_q         <= hold_d;
      gap_q          <= gap_d;
      entry_sensor_q <= entry_sensor_d;
      exit_sensor_q  <= exit_sensor_d;
      switch_q       <= switch_d;
      rejected_q     <= rejected_d;
    end
  end

  assign bus.entry_sensor = entry_sensor_q;
  assign bus.exit_sensor  = exit_sensor_q;
  assign bus.switch       = switch_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.rejected     = rejected_q;
endmodule
